ram_mfc_responder: RTL and testbench

//   Memory-side responder for the data path's MOV/MFC memory handshake. Holds a 512-byte,
//   big-endian, byte-addressed array (memory[a] = MSB). Serves byte/halfword/word reads and

---
 rtl/ram_defs_pkg.sv | 8 +
 rtl/ram_lane_mux.sv | 22 ++
 rtl/ram_mfc_responder.sv | 130 +++++++++++++
 tb/tb_ram_mfc_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ram_defs_pkg.sv
// ram_defs_pkg: data_type codes, FSM states and default wait-state latency shared by the responder.
package ram_defs_pkg;
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;
  localparam int DEFAULT_LATENCY = 3;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
endpackage

// File: rtl/ram_lane_mux.sv
// ram_lane_mux: big-endian byte steering; byte 0 is m[a], reserved data_type behaves as word.
module ram_lane_mux
  import ram_defs_pkg::*;
(
  input  logic [1:0]      dt_i,
  input  logic [31:0]     din_i,
  input  logic [3:0][7:0] rbytes_i,
  output logic [31:0]     rdata_o,
  output logic [3:0]      be_o,
  output logic [3:0][7:0] wbytes_o
);
  always_comb begin
    rdata_o     = dt_i == DT_BYTE ? {24'b0, rbytes_i[0]} :
                  dt_i == DT_HALF ? {16'b0, rbytes_i[0], rbytes_i[1]} :
                  {rbytes_i[0], rbytes_i[1], rbytes_i[2], rbytes_i[3]};
    be_o        = dt_i == DT_BYTE ? 4'b0001 : dt_i == DT_HALF ? 4'b0011 : 4'b1111;
    wbytes_o[0] = dt_i == DT_BYTE ? din_i[7:0] : dt_i == DT_HALF ? din_i[15:8] : din_i[31:24];
    wbytes_o[1] = dt_i == DT_HALF ? din_i[7:0] : din_i[23:16];
    wbytes_o[2] = din_i[15:8];
    wbytes_o[3] = din_i[7:0];
  end
endmodule

// File: rtl/ram_mfc_responder.sv
// ram_mfc_responder: wait-stated byte RAM answering MOV with MFC after LATENCY edges.
// Define ALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module ram_mfc_responder
  import ram_defs_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = 9
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        data_type,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              mfc,
  output logic              align_err
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        dt_q, dt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d, dout_q, dout_d;
  logic              mfc_q, mfc_d, align_q, align_d;
  logic [7:0]        mem_q [2**ADDR_W];
  logic              idle, access, mis, we, op_rw;
  logic [1:0]        op_dt;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_din, rdata;
  logic [3:0]        be;
  logic [3:0][7:0]   rbytes, wbytes;

  // With LATENCY=1 the access happens on the capture edge, so operands bypass the capture regs.
  assign idle    = state_q == S_IDLE;
  assign op_rw   = idle ? rw : rw_q;
  assign op_dt   = idle ? data_type : dt_q;
  assign op_addr = idle ? address : addr_q;
  assign op_din  = idle ? data_in : din_q;
  assign access  = mov && (idle ? LATENCY == 1 : state_q == S_BUSY && cnt_q == 4'd0);
`ifdef ALIGN_CHECK_EN
  assign mis = (op_dt == DT_HALF && op_addr[0]) || (op_dt[1] && op_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign we = reset && access && !op_rw && !mis;

  for (genvar i = 0; i < 4; i++) begin : g_rd
    assign rbytes[i] = mem_q[op_addr + ADDR_W'(i)];
  end

  ram_lane_mux u_lane (
    .dt_i    (op_dt),
    .din_i   (op_din),
    .rbytes_i(rbytes),
    .rdata_o (rdata),
    .be_o    (be),
    .wbytes_o(wbytes)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    dt_d    = dt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    align_d = align_q;
    if (idle && mov) begin
      rw_d    = rw;
      dt_d    = data_type;
      addr_d  = address;
      din_d   = data_in;
      cnt_d   = 4'(LATENCY - 1);
      state_d = S_BUSY;
    end
    if (state_q == S_BUSY) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = mov ? S_BUSY : S_IDLE;
    end
    if (access) begin
      state_d = S_DONE;
      mfc_d   = 1'b1;
      align_d = mis;
      dout_d  = mis ? 32'h0 : op_rw ? rdata : dout_q;
    end
    if (state_q == S_DONE && !mov) begin
      state_d = S_IDLE;
      mfc_d   = 1'b0;
      align_d = 1'b0;
    end
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      dt_q    <= 2'b00;
      addr_q  <= '0;
      din_q   <= 32'h0;
      dout_q  <= 32'h0;
      mfc_q   <= 1'b0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dt_q    <= dt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      align_q <= align_d;
    end
  end

  // The array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge main_clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem_q[op_addr + ADDR_W'(i)] <= wbytes[i];
  end

  assign data_out  = dout_q;
  assign mfc       = mfc_q;
  assign align_err = align_q;
endmodule

// File: tb/tb_ram_mfc_responder.sv
// tb_ram_mfc_responder: directed plus random MOV/MFC traffic checked against a byte-array model.
module tb_ram_mfc_responder;
  logic        main_clk = 1'b0;
  logic        reset = 1'b0;
  logic        mov = 1'b0, rw = 1'b0;
  logic [1:0]  data_type = 2'b00;
  logic [8:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        mfc, align_err;
  logic [7:0]  ref_mem [512];
  logic [31:0] last_out = '0;
  int          checks = 0, passed = 0;

  ram_mfc_responder dut (
    .main_clk(main_clk), .reset(reset), .mov(mov), .rw(rw), .data_type(data_type),
    .address(address), .data_in(data_in), .data_out(data_out), .mfc(mfc), .align_err(align_err)
  );

  always #5 main_clk = ~main_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] dt);
    return dt == 2'd0 ? 1 : dt == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic misaligned(input logic [1:0] dt, input int a);
`ifdef ALIGN_CHECK_EN
    return (nbytes(dt) == 2 && a % 2 != 0) || (nbytes(dt) == 4 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input int a, input logic [1:0] dt);
    logic [31:0] v = 0;
    for (int i = 0; i < nbytes(dt); i++) v = (v << 8) | 32'(ref_mem[(a + i) % 512]);
    return v;
  endfunction

  task automatic model_write(input int a, input logic [1:0] dt, input logic [31:0] d);
    int n = nbytes(dt);
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 512] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  // One full handshake; inputs are scrambled after the capture edge to prove they are ignored.
  task automatic op(input logic r, input logic [1:0] dt, input int a, input logic [31:0] d);
    int n = 0;
    logic m;
    logic [31:0] exp;
    @(negedge main_clk);
    rw = r; data_type = dt; address = 9'(a); data_in = d; mov = 1'b1;
    @(posedge main_clk); #1;
    rw = 1'($urandom); data_type = 2'($urandom); address = 9'($urandom); data_in = $urandom;
    while (!mfc && n < 20) begin
      @(posedge main_clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd3);
    m   = misaligned(dt, a);
    exp = m ? 32'h0 : r ? model_read(a, dt) : last_out;
    if (!r && !m) model_write(a, dt, d);
    check("data_out", data_out, exp);
    check("align_err", {31'b0, align_err}, {31'b0, m});
    last_out = exp;
    @(negedge main_clk); mov = 1'b0;
    @(posedge main_clk); #1;
    check("mfc_release", {31'b0, mfc}, 32'h0);
    check("align_release", {31'b0, align_err}, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge main_clk);
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_mfc", {31'b0, mfc}, 32'h0);
    check("rst_align", {31'b0, align_err}, 32'h0);
    @(negedge main_clk); reset = 1'b1;

    op(1'b0, 2'd2, 0, 32'hDEADBEEF);
    for (int a = 4; a < 512; a += 4) op(1'b0, 2'd2, a, $urandom);

    op(1'b1, 2'd2, 0, 32'h0);
    check("t1_word", data_out, 32'hDEADBEEF);

    op(1'b0, 2'd0, 5, 32'h000000A5);
    op(1'b1, 2'd0, 5, 32'h0);
    check("t2_byte", data_out, 32'h000000A5);
    op(1'b1, 2'd0, 4, 32'h0);
    op(1'b1, 2'd0, 6, 32'h0);

    op(1'b0, 2'd1, 510, 32'h00001234);
    op(1'b1, 2'd2, 510, 32'h0);
    check("t3_wrap_hi", data_out >> 16, 32'h1234);

    @(negedge main_clk);
    rw = 1'b0; data_type = 2'd2; address = 9'd8; data_in = $urandom; mov = 1'b1;
    @(posedge main_clk);
    @(negedge main_clk); mov = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge main_clk); #1;
      check("t4_no_mfc", {31'b0, mfc}, 32'h0);
    end
    op(1'b1, 2'd2, 8, 32'h0);

    @(negedge main_clk);
    rw = 1'b0; data_type = 2'd2; address = 9'd12; data_in = 32'hCAFEF00D; mov = 1'b1;
    repeat (2) @(posedge main_clk);
    #2 reset = 1'b0;
    #1;
    check("t5_mfc", {31'b0, mfc}, 32'h0);
    check("t5_data_out", data_out, 32'h0);
    last_out = 32'h0;
    @(negedge main_clk); mov = 1'b0; reset = 1'b1;
    op(1'b1, 2'd2, 12, 32'h0);

`ifdef ALIGN_CHECK_EN
    op(1'b1, 2'd2, 2, 32'h0);
    op(1'b0, 2'd2, 2, 32'hFFFFFFFF);
    check("t6_zero", data_out, 32'h0);
    op(1'b1, 2'd2, 0, 32'h0);
    op(1'b1, 2'd2, 4, 32'h0);
`endif

    for (int i = 0; i < 40; i++)
      op(1'($urandom), 2'($urandom), int'($urandom_range(0, 511)), $urandom);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
